// File: rtl/alu_register_muldiv_pkg.sv
// Shared encodings for the register-register ALU: funct7/funct3 codes,
// FSM states and the encoding legality check.
package alu_register_muldiv_pkg;

  localparam int unsigned F7_W = 7;
  localparam int unsigned F3_W = 3;

  localparam logic [F7_W-1:0] F7_BASE   = 7'h00;
  localparam logic [F7_W-1:0] F7_ALT    = 7'h20;
  localparam logic [F7_W-1:0] F7_MULDIV = 7'h01;

  localparam logic [F3_W-1:0] F3_ADD_SUB = 3'd0;
  localparam logic [F3_W-1:0] F3_SLL     = 3'd1;
  localparam logic [F3_W-1:0] F3_SLT     = 3'd2;
  localparam logic [F3_W-1:0] F3_SLTU    = 3'd3;
  localparam logic [F3_W-1:0] F3_XOR     = 3'd4;
  localparam logic [F3_W-1:0] F3_SRL_SRA = 3'd5;
  localparam logic [F3_W-1:0] F3_OR      = 3'd6;
  localparam logic [F3_W-1:0] F3_AND     = 3'd7;

  localparam logic [F3_W-1:0] F3_MUL    = 3'd0;
  localparam logic [F3_W-1:0] F3_MULH   = 3'd1;
  localparam logic [F3_W-1:0] F3_MULHSU = 3'd2;
  localparam logic [F3_W-1:0] F3_MULHU  = 3'd3;
  localparam logic [F3_W-1:0] F3_DIV    = 3'd4;
  localparam logic [F3_W-1:0] F3_DIVU   = 3'd5;
  localparam logic [F3_W-1:0] F3_REM    = 3'd6;
  localparam logic [F3_W-1:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // ALT only qualifies ADD->SUB and SRL->SRA; MULDIV exists only with the M extension
  function automatic logic is_legal(input logic [F7_W-1:0] f7, input logic [F3_W-1:0] f3,
                                    input logic enable_m);
    case (f7)
      F7_BASE:   return 1'b1;
      F7_ALT:    return (f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA);
      F7_MULDIV: return enable_m;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_register_muldiv_if.sv
// Request/response handshake between register-read, the ALU and writeback.
interface alu_register_muldiv_if #(parameter int unsigned XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      subfunction_3;
  logic [6:0]      subfunction_7;
  logic [XLEN-1:0] input_register1_value;
  logic [XLEN-1:0] input_register2_value;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result_to_write_rd;
  logic            decoding_error;

  modport master (
    output in_valid, subfunction_3, subfunction_7,
           input_register1_value, input_register2_value, out_ready,
    input  in_ready, out_valid, result_to_write_rd, decoding_error
  );

  modport slave (
    input  in_valid, subfunction_3, subfunction_7,
           input_register1_value, input_register2_value, out_ready,
    output in_ready, out_valid, result_to_write_rd, decoding_error
  );
endinterface

// File: rtl/alu_iterative_muldiv.sv
// One-bit-per-cycle multiply (shift-add) and divide (restoring) on operand
// magnitudes; sign fix-up and result selection are folded into the last step.
module alu_iterative_muldiv
  import alu_register_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] mag_a,
  input  logic [XLEN-1:0] mag_b,
  input  logic            sign_a,
  input  logic            sign_b,
  output logic            done_c,
  output logic [XLEN-1:0] result_c
);
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned ACC_W = 2 * XLEN;

  // Multiply: {partial, multiplier}; divide: {remainder, dividend/quotient}
  logic [ACC_W-1:0] acc;
  logic [XLEN-1:0]  operand_b;
  logic [2:0]       op_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic [CNT_W-1:0] count;

  logic [XLEN:0]    mul_sum;
  logic [XLEN:0]    div_shift;
  logic [XLEN:0]    div_diff;
  logic [ACC_W-1:0] next_acc;
  logic [ACC_W-1:0] prod_fix;
  logic [XLEN-1:0]  quo_fix;
  logic [XLEN-1:0]  rem_fix;

  always_comb begin
    mul_sum   = {1'b0, acc[ACC_W-1:XLEN]} + (acc[0] ? {1'b0, operand_b} : '0);
    div_shift = acc[ACC_W-1:XLEN-1];
    div_diff  = div_shift - {1'b0, operand_b};
    if (op_q[2]) begin
      next_acc = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      next_acc = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // Quotient and product negate on differing signs; remainder follows the dividend
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -next_acc : next_acc;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -next_acc[XLEN-1:0] : next_acc[XLEN-1:0];
    rem_fix  = sign_a_q ? -next_acc[ACC_W-1:XLEN] : next_acc[ACC_W-1:XLEN];
    case (op_q)
      F3_MUL:                       result_c = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result_c = prod_fix[ACC_W-1:XLEN];
      F3_DIV, F3_DIVU:              result_c = quo_fix;
      F3_REM, F3_REMU:              result_c = rem_fix;
      default:                      result_c = '0;
    endcase
  end

  assign done_c = (count == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      operand_b <= '0;
      op_q      <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      count     <= '0;
    end else if (start) begin
      acc       <= {XLEN'(0), mag_a};
      operand_b <= mag_b;
      op_q      <= op;
      sign_a_q  <= sign_a;
      sign_b_q  <= sign_b;
      count     <= CNT_W'(XLEN);
    end else if (count != '0) begin
      acc   <= next_acc;
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_register_muldiv.sv
// Handshaked RV32I OP / RV32M ALU: single-cycle base ops and division special
// cases, iterative multiply/divide through alu_iterative_muldiv.
module alu_register_muldiv
  import alu_register_muldiv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  alu_register_muldiv_if.slave bus
);
  localparam int unsigned SHAMT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            derr_q;

  logic [2:0]          f3;
  logic [6:0]          f7;
  logic [XLEN-1:0]     rs1;
  logic [XLEN-1:0]     rs2;
  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic [SHAMT_W-1:0]  shamt;
  logic [XLEN-1:0]     sra_res;

  assign f3    = bus.subfunction_3;
  assign f7    = bus.subfunction_7;
  assign rs1   = bus.input_register1_value;
  assign rs2   = bus.input_register2_value;
  assign rs1_s = rs1;
  assign rs2_s = rs2;
  assign shamt = rs2[SHAMT_W-1:0];
  assign sra_res = rs1_s >>> shamt;

  logic legal;
  logic is_alt;
  logic is_m;
  logic div_special;
  logic md_start;
  logic sign_a;
  logic sign_b;
  logic md_done;
  logic [XLEN-1:0] md_result;
  logic [XLEN-1:0] base_res;
  logic [XLEN-1:0] special_res;

  assign legal  = is_legal(f7, f3, ENABLE_M);
  assign is_alt = (f7 == F7_ALT);
  assign is_m   = ENABLE_M && (f7 == F7_MULDIV);

  // Divide by zero and MIN/-1 resolve without iterating
  assign div_special = f3[2] && ((rs2 == '0) || (!f3[0] && rs1 == XMIN && rs2 == '1));
  assign md_start    = (state == ST_IDLE) && bus.in_valid && is_m && !div_special;

  assign sign_a = rs1[XLEN-1] && (f3 == F3_MULH || f3 == F3_MULHSU || f3 == F3_DIV || f3 == F3_REM);
  assign sign_b = rs2[XLEN-1] && (f3 == F3_MULH || f3 == F3_DIV || f3 == F3_REM);

  always_comb begin
    base_res = '0;
    case (f3)
      F3_ADD_SUB: base_res = is_alt ? rs1 - rs2 : rs1 + rs2;
      F3_SLL:     base_res = rs1 << shamt;
      F3_SLT:     base_res = XLEN'(rs1_s < rs2_s);
      F3_SLTU:    base_res = XLEN'(rs1 < rs2);
      F3_XOR:     base_res = rs1 ^ rs2;
      F3_SRL_SRA: base_res = is_alt ? sra_res : rs1 >> shamt;
      F3_OR:      base_res = rs1 | rs2;
      F3_AND:     base_res = rs1 & rs2;
      default:    base_res = '0;
    endcase
  end

  always_comb begin
    special_res = '0;
    if (rs2 == '0) special_res = f3[1] ? rs1 : '1;
    else           special_res = f3[1] ? '0 : XMIN;
  end

  alu_iterative_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start    (md_start),
    .op       (f3),
    .mag_a    (sign_a ? -rs1 : rs1),
    .mag_b    (sign_b ? -rs2 : rs2),
    .sign_a   (sign_a),
    .sign_b   (sign_b),
    .done_c   (md_done),
    .result_c (md_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      derr_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            derr_q     <= !legal;
            if (!legal) begin
              result_q    <= '0;
              out_valid_q <= 1'b1;
              state       <= ST_DONE;
            end else if (!is_m) begin
              result_q    <= base_res;
              out_valid_q <= 1'b1;
              state       <= ST_DONE;
            end else if (!f3[2]) begin
              state <= ST_MUL;
            end else if (div_special) begin
              result_q    <= special_res;
              out_valid_q <= 1'b1;
              state       <= ST_DONE;
            end else begin
              state <= ST_DIV;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (md_done) begin
            result_q    <= md_result;
            out_valid_q <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready           = in_ready_q;
  assign bus.out_valid          = out_valid_q;
  assign bus.result_to_write_rd = result_q;
  assign bus.decoding_error     = derr_q;

endmodule

// File: tb/tb_alu_register_muldiv.sv
// Directed bench for alu_register_muldiv: scoreboarded results, latency,
// backpressure, mid-operation reset and the ENABLE_M=0 variant.
module tb_alu_register_muldiv;
  import alu_register_muldiv_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
  } exp_t;

  logic clk;
  logic rst;
  bit   sel;
  logic        drv_valid;
  logic [2:0]  drv_f3;
  logic [6:0]  drv_f7;
  logic [31:0] drv_a;
  logic [31:0] drv_b;
  logic        drv_out_ready;

  int tests;
  int fails;
  exp_t sb[$];

  alu_register_muldiv_if #(.XLEN(32)) bus ();
  alu_register_muldiv_if #(.XLEN(32)) bus_nm ();

  alu_register_muldiv #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );
  alu_register_muldiv #(.XLEN(32), .ENABLE_M(1'b0)) dut_nm (
    .clk(clk), .reset(rst), .bus(bus_nm)
  );

  assign bus.in_valid                 = drv_valid & ~sel;
  assign bus_nm.in_valid              = drv_valid & sel;
  assign bus.subfunction_3            = drv_f3;
  assign bus_nm.subfunction_3         = drv_f3;
  assign bus.subfunction_7            = drv_f7;
  assign bus_nm.subfunction_7         = drv_f7;
  assign bus.input_register1_value    = drv_a;
  assign bus_nm.input_register1_value = drv_a;
  assign bus.input_register2_value    = drv_b;
  assign bus_nm.input_register2_value = drv_b;
  assign bus.out_ready                = drv_out_ready;
  assign bus_nm.out_ready             = drv_out_ready;

  logic        obs_in_ready;
  logic        obs_out_valid;
  logic [31:0] obs_res;
  logic        obs_err;
  assign obs_in_ready  = sel ? bus_nm.in_ready : bus.in_ready;
  assign obs_out_valid = sel ? bus_nm.out_valid : bus.out_valid;
  assign obs_res       = sel ? bus_nm.result_to_write_rd : bus.result_to_write_rd;
  assign obs_err       = sel ? bus_nm.decoding_error : bus.decoding_error;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request, push its expectation, and return #1 after the accept edge
  task automatic issue(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ee, input int el);
    int waited;
    sb.push_back('{res: er, err: ee, lat: el});
    drv_f7 = f7; drv_f3 = f3; drv_a = a; drv_b = b; drv_valid = 1'b1;
    waited = 0;
    while (!obs_in_ready && waited < 200) begin
      @(posedge clk); #1; waited++;
    end
    if (waited >= 200) check({tag, "_accept"}, 32'(obs_in_ready), 32'd1);
    @(posedge clk); #1;
    drv_valid = 1'b0;
  endtask

  task automatic collect(input string tag);
    int lat;
    exp_t e;
    lat = 1;
    while (!obs_out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    e = sb.pop_front();
    check({tag, "_valid"}, 32'(obs_out_valid), 32'd1);
    check({tag, "_res"}, obs_res, e.res);
    check({tag, "_derr"}, 32'(obs_err), 32'(e.err));
    check({tag, "_lat"}, 32'(lat), 32'(e.lat));
  endtask

  task automatic send(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic ee, input int el);
    issue(tag, f7, f3, a, b, er, ee, el);
    collect(tag);
    if (drv_out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int stale;
    tests = 0; fails = 0;
    sel = 1'b0; rst = 1'b1; drv_valid = 1'b0; drv_f3 = '0; drv_f7 = '0;
    drv_a = '0; drv_b = '0; drv_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(obs_out_valid), 32'd0);
    check("rst_in_ready", 32'(obs_in_ready), 32'd1);
    check("rst_result", obs_res, 32'd0);
    check("rst_derr", 32'(obs_err), 32'd0);
    check("rst_nm_in_ready", 32'(bus_nm.in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Base operations
    send("add",  F7_BASE, F3_ADD_SUB, 32'd5, 32'd7, 32'd12, 1'b0, 1);
    send("sub",  F7_ALT,  F3_ADD_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
    send("sra",  F7_ALT,  F3_SRL_SRA, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 1);
    send("srl",  F7_BASE, F3_SRL_SRA, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, 1);
    send("sll",  F7_BASE, F3_SLL, 32'd1, 32'h3F, 32'h8000_0000, 1'b0, 1);
    send("slt",  F7_BASE, F3_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
    send("sltu", F7_BASE, F3_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);

    // Iterative multiply
    send("mulh",   F7_MULDIV, F3_MULH, 32'hFFFF_FFFD, 32'h4000_0000, 32'hFFFF_FFFF, 1'b0, 33);
    send("mulhu",  F7_MULDIV, F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
    send("mul",    F7_MULDIV, F3_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 33);
    send("mulhsu", F7_MULDIV, F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);

    // Iterative divide and special cases
    send("div",     F7_MULDIV, F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
    send("rem",     F7_MULDIV, F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
    send("divu",    F7_MULDIV, F3_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 33);
    send("remu",    F7_MULDIV, F3_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 33);
    send("divu_z",  F7_MULDIV, F3_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
    send("remu_z",  F7_MULDIV, F3_REMU, 32'd7, 32'd0, 32'd7, 1'b0, 1);
    send("div_ovf", F7_MULDIV, F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
    send("rem_ovf", F7_MULDIV, F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);

    // Illegal encodings, decoding_error clears on the next legal result
    send("ill_f7",  7'h10, F3_ADD_SUB, 32'd3, 32'd4, 32'd0, 1'b1, 1);
    send("clr_add", F7_BASE, F3_ADD_SUB, 32'd1, 32'd1, 32'd2, 1'b0, 1);
    send("ill_alt", F7_ALT, F3_XOR, 32'd3, 32'd4, 32'd0, 1'b1, 1);
    sel = 1'b1;
    send("nm_mul", F7_MULDIV, F3_MUL, 32'd3, 32'd4, 32'd0, 1'b1, 1);
    send("nm_add", F7_BASE, F3_ADD_SUB, 32'd3, 32'd4, 32'd7, 1'b0, 1);
    sel = 1'b0;

    // Backpressure: result held, new requests ignored
    drv_out_ready = 1'b0;
    issue("bp_div", F7_MULDIV, F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
    collect("bp_div");
    for (int i = 0; i < 5; i++) begin
      drv_f7 = F7_BASE; drv_f3 = F3_ADD_SUB; drv_a = 32'd1; drv_b = 32'd1; drv_valid = 1'b1;
      @(posedge clk); #1;
      drv_valid = 1'b0;
      check("bp_hold_valid", 32'(obs_out_valid), 32'd1);
      check("bp_hold_res", obs_res, 32'hFFFF_FFFD);
      check("bp_in_ready", 32'(obs_in_ready), 32'd0);
    end
    drv_out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(obs_out_valid), 32'd0);
    check("bp_release_ready", 32'(obs_in_ready), 32'd1);
    @(posedge clk); #1;
    check("bp_no_ghost", 32'(obs_out_valid), 32'd0);

    // Reset in the middle of a divide
    issue("rst_div", F7_MULDIV, F3_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 33);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    sb.delete();
    check("midrst_out_valid", 32'(obs_out_valid), 32'd0);
    check("midrst_in_ready", 32'(obs_in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    stale = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (obs_out_valid) stale++;
    end
    check("midrst_no_stale", 32'(stale), 32'd0);
    send("post_rst_add", F7_BASE, F3_OR, 32'h0F0, 32'h00F, 32'h0FF, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_register_muldiv.md
Name: alu_register_muldiv

Overview:
- Parametrised, handshaked successor to the single-cycle R-type ALU.
- Executes all RV32I OP-opcode instructions (funct7 0x00/0x20) plus the RV32M extension (funct7 0x01): MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits between the register-read stage and writeback; the core stalls on in_ready/out_valid.
- Base ops take 1 cycle; multiply and divide are iterative, 1 bit per cycle.

Parameters:
- XLEN, 32: operand/result width; must be a power of two, 8 or more.
- SHAMT_W, $clog2(XLEN): shift-amount width, derived, not overridable.
- ENABLE_M, 1: when 0, every funct7 0x01 encoding reports decoding_error.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- subfunction_3  in  3  instruction funct3
- subfunction_7  in  7  instruction funct7
- input_register1_value  in  XLEN  rs1 value
- input_register2_value  in  XLEN  rs2 value
- out_valid  out  1  result present; held until taken
- out_ready  in  1  writeback accepts the result
- result_to_write_rd  out  XLEN  rd value
- decoding_error  out  1  qualifies the current result as an illegal encoding

Behaviour:
- Semantics: rd = rs1 op rs2.
  - SUB = rs1 - rs2.
  - SLT/SLTU compare rs1 < rs2 (signed/unsigned).
  - Shifts shift rs1 by rs2[SHAMT_W-1:0].
  - SRA sign-fills.
- Reset: state IDLE; out_valid=0, decoding_error=0, result_to_write_rd=0, in_ready=1. Reset asserted mid-operation aborts it with no output.
- FSM states and transitions:
  - IDLE: in_ready=1.
    - On in_valid, operands and funct fields are captured.
    - Base op or illegal encoding: go to DONE.
    - MUL*: go to MUL with count=XLEN.
    - DIV*/REM*: go to DIV with count=XLEN, unless a div special case applies, which goes to DONE.
  - MUL: shift-add on operand magnitudes, 2*XLEN accumulator; count decrements each cycle; at 0 go to DONE.
  - DIV: restoring shift-subtract on magnitudes; at count 0 go to DONE.
  - DONE: out_valid=1; result and decoding_error stable. On out_ready go to IDLE.
- in_ready=0 in every state other than IDLE; there is no back-to-back overlap.
- Latency (accept edge to out_valid high): base/illegal/special = 1 cycle; mul/div = XLEN+1 cycles.
- Sign fix-up, applied in the final cycle:
  - MULH uses signed x signed; MULHSU uses signed rs1 x unsigned rs2.
  - The product is negated when the operand signs differ.
  - The quotient is negated when the signs differ; the remainder takes the sign of the dividend.
- Result selection: MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Division special cases (1-cycle, no iteration):
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> rs1.
  - Signed overflow (rs1 = MIN, rs2 = -1): DIV -> MIN; REM -> 0.
- Illegal encoding: result 0, decoding_error=1 in DONE. decoding_error is not sticky; it clears when the next result is produced.
- Illegal encodings are:
  - Any funct7 other than 0x00/0x20/0x01.
  - funct7 0x20 with funct3 other than ADD/SRL.
  - funct7 0x01 when ENABLE_M=0.
- in_valid while busy is ignored; the requester must hold it until in_ready.

Decomposition:
- Shared header define.vh gains:
  - funct7 codes BASE (0x00), ALT (0x20), MULDIV (0x01).
  - M-extension funct3 codes.
  - FSM state encodings.
- Existing funct3 defines are reused.
- One sub-module: alu_iterative_muldiv.
  - Ports: start, op, magnitudes, signs; done, result.
  - Contains the MUL/DIV datapath and counter.
  - The top keeps the FSM, handshake, base ops and special cases.

Test Plan:
- ADD 5+7, then SUB 5-7 (XLEN=32), out_ready=1 -> each out_valid 1 cycle after accept; results 12 and 0xFFFFFFFE; decoding_error=0.
- SRA rs1=0x80000000, rs2=0x24 (shamt 4) -> 0xF8000000; SRL on the same operands -> 0x08000000.
- MULH rs1=-3, rs2=0x40000000 -> out_valid exactly 33 cycles after accept, result 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MUL on the same operands -> 1.
- DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF at 1-cycle latency; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
- funct7=0x10 -> result 0, decoding_error=1; the following legal ADD clears decoding_error. Repeat with ENABLE_M=0 and MUL -> decoding_error=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles after DIV completes -> result stable, in_ready=0; in_valid pulses during the wait are ignored.
  - Assert reset at cycle 10 of a DIV -> out_valid=0 and in_ready=1 immediately; no stale result afterwards.
